alu_operand_stage: RTL

//  Issue stage directly upstream of the ALU: registers one decoded integer op, resolves rs1/rs2 from the

---
 rtl/alu_operand_stage_if.sv | 76 +++++++
 rtl/alu_operand_stage.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage_if.sv
// Bundle of the operand stage's decoder, forwarding and ALU-side signals.
// The slave modport is the stage. The master modport is its environment:
// the decoder, register file, forwarding network and EX stage.
interface alu_operand_stage_if #(
    parameter int unsigned WORD    = 32,
    parameter int unsigned FUNC3   = 3,
    parameter int unsigned REG_IDX = 5
);
    // Pipeline kill
    logic               flush;

    // Decoder side
    logic               in_valid;
    logic               in_ready;
    logic [FUNC3-1:0]   in_func3;
    logic               in_mode_flag;
    logic               in_imm_flag;
    logic [WORD-1:0]    in_imm;
    logic [REG_IDX-1:0] in_rs1_idx;
    logic [REG_IDX-1:0] in_rs2_idx;
    logic [REG_IDX-1:0] in_rd_idx;

    // Register file read data for in_rs1_idx / in_rs2_idx
    logic [WORD-1:0]    rf_rs1_data;
    logic [WORD-1:0]    rf_rs2_data;

    // Forwarding from EX and WB
    logic               ex_fwd_en;
    logic [REG_IDX-1:0] ex_fwd_rd;
    logic               ex_fwd_load;
    logic [WORD-1:0]    ex_fwd_data;
    logic               wb_fwd_en;
    logic [REG_IDX-1:0] wb_fwd_rd;
    logic [WORD-1:0]    wb_fwd_data;

    // ALU side
    logic               out_valid;
    logic               out_ready;
    logic [FUNC3-1:0]   out_func3;
    logic               out_mode_flag;
    logic               out_imm_flag;
    logic [WORD-1:0]    out_rs1;
    logic [WORD-1:0]    out_rs2;
    logic [REG_IDX-1:0] out_rd_idx;

    // Performance counter
    logic [31:0]        stall_count;

    modport master (
        output flush,
        output in_valid, in_func3, in_mode_flag, in_imm_flag, in_imm,
        output in_rs1_idx, in_rs2_idx, in_rd_idx,
        input  in_ready,
        output rf_rs1_data, rf_rs2_data,
        output ex_fwd_en, ex_fwd_rd, ex_fwd_load, ex_fwd_data,
        output wb_fwd_en, wb_fwd_rd, wb_fwd_data,
        input  out_valid, out_func3, out_mode_flag, out_imm_flag,
        input  out_rs1, out_rs2, out_rd_idx,
        output out_ready,
        input  stall_count
    );

    modport slave (
        input  flush,
        input  in_valid, in_func3, in_mode_flag, in_imm_flag, in_imm,
        input  in_rs1_idx, in_rs2_idx, in_rd_idx,
        output in_ready,
        input  rf_rs1_data, rf_rs2_data,
        input  ex_fwd_en, ex_fwd_rd, ex_fwd_load, ex_fwd_data,
        input  wb_fwd_en, wb_fwd_rd, wb_fwd_data,
        output out_valid, out_func3, out_mode_flag, out_imm_flag,
        output out_rs1, out_rs2, out_rd_idx,
        input  out_ready,
        output stall_count
    );
endinterface

// File: rtl/alu_operand_stage.sv
// Issue stage directly upstream of the ALU.
// It registers one decoded integer op and resolves rs1/rs2 from the register
// file plus EX/WB forwarding. For I-type ops the immediate replaces rs2.
// A load in EX whose result is still pending cannot be forwarded. An op that
// reads such a register is held at the input (in_ready low) until EX advances.
module alu_operand_stage #(
    parameter int unsigned WORD    = 32,
    parameter int unsigned FUNC3   = 3,
    parameter int unsigned REG_IDX = 5
) (
    input logic                clk,
    input logic                rstn,
    alu_operand_stage_if.slave bus
);
    localparam int unsigned CntW = 32;

    // Registered op toward the ALU
    logic               out_valid_q;
    logic [FUNC3-1:0]   func3_q;
    logic               mode_flag_q;
    logic               imm_flag_q;
    logic [WORD-1:0]    rs1_q;
    logic [WORD-1:0]    rs2_q;
    logic [REG_IDX-1:0] rd_idx_q;

    // Stall counter
    logic [CntW-1:0]    stall_cnt_q;
    logic [CntW-1:0]    stall_cnt_d;

    // Combinational resolve / handshake terms
    logic               ex_hit_rs1;
    logic               ex_hit_rs2;
    logic               wb_hit_rs1;
    logic               wb_hit_rs2;
    logic [WORD-1:0]    rs1_res;
    logic [WORD-1:0]    rs2_res;
    logic [WORD-1:0]    rs2_sel;
    logic               load_hit_rs1;
    logic               load_hit_rs2;
    logic               hazard;
    logic               in_ready;
    logic               accept;
    logic               stall;

    // Forwarding matches; an EX load has no data yet, so it never forwards.
    always_comb begin
        ex_hit_rs1 = bus.ex_fwd_en && !bus.ex_fwd_load && (bus.ex_fwd_rd == bus.in_rs1_idx);
        ex_hit_rs2 = bus.ex_fwd_en && !bus.ex_fwd_load && (bus.ex_fwd_rd == bus.in_rs2_idx);
        wb_hit_rs1 = bus.wb_fwd_en && (bus.wb_fwd_rd == bus.in_rs1_idx);
        wb_hit_rs2 = bus.wb_fwd_en && (bus.wb_fwd_rd == bus.in_rs2_idx);
    end

    // Operand resolve: x0 reads zero, EX beats WB, WB beats the register file.
    always_comb begin
        if (bus.in_rs1_idx == '0) begin
            rs1_res = '0;
        end else if (ex_hit_rs1) begin
            rs1_res = bus.ex_fwd_data;
        end else if (wb_hit_rs1) begin
            rs1_res = bus.wb_fwd_data;
        end else begin
            rs1_res = bus.rf_rs1_data;
        end

        if (bus.in_rs2_idx == '0) begin
            rs2_res = '0;
        end else if (ex_hit_rs2) begin
            rs2_res = bus.ex_fwd_data;
        end else if (wb_hit_rs2) begin
            rs2_res = bus.wb_fwd_data;
        end else begin
            rs2_res = bus.rf_rs2_data;
        end

        rs2_sel = bus.in_imm_flag ? bus.in_imm : rs2_res;
    end

    // Load-use detection; rs2 is not a real source for I-type ops.
    always_comb begin
        load_hit_rs1 = (bus.ex_fwd_rd == bus.in_rs1_idx);
        load_hit_rs2 = !bus.in_imm_flag && (bus.ex_fwd_rd == bus.in_rs2_idx);
        hazard       = bus.in_valid && bus.ex_fwd_en && bus.ex_fwd_load &&
                       (bus.ex_fwd_rd != '0) && (load_hit_rs1 || load_hit_rs2);
    end

    // Input handshake and saturating stall counter next state.
    always_comb begin
        in_ready    = rstn && !bus.flush && !hazard && (!out_valid_q || bus.out_ready);
        accept      = bus.in_valid && in_ready;
        stall       = bus.in_valid && !in_ready;
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Output register: flush beats accept, accept beats drain, else hold.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            func3_q     <= '0;
            mode_flag_q <= 1'b0;
            imm_flag_q  <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_idx_q    <= '0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            func3_q     <= bus.in_func3;
            mode_flag_q <= bus.in_mode_flag;
            imm_flag_q  <= bus.in_imm_flag;
            rs1_q       <= rs1_res;
            rs2_q       <= rs2_sel;
            rd_idx_q    <= bus.in_rd_idx;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_func3     = func3_q;
    assign bus.out_mode_flag = mode_flag_q;
    assign bus.out_imm_flag  = imm_flag_q;
    assign bus.out_rs1       = rs1_q;
    assign bus.out_rs2       = rs2_q;
    assign bus.out_rd_idx    = rd_idx_q;
    assign bus.stall_count   = stall_cnt_q;

endmodule
